// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM pipeline stage: datapath widths, FSM state
// encoding, mem_err codes and a word-alignment helper.
package pipeline_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_CONFLICT = 2'b11;

    localparam logic [REG_W-1:0] REG_NONE = 4'd0;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus.
//   master (MEM stage): drives req, we, addr, wdata; receives rdata, ack.
//   slave  (memory)   : the mirror image.
// req is held until ack or abort; ack is a single-cycle strobe and rdata is
// only meaningful alongside it.
interface mem_access_stage_if
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a bus ack.
//   clock, reset_n : stage clock, async active-low reset
//   clear          : zero the count (priority over enable)
//   enable         : advance the count by one
//   last           : count has reached TIMEOUT-1 (final allowed wait cycle)
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic last
);
    localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

    logic [7:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign last = (count_q == LastCount);
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs one req/ack data-memory transaction per load/store,
// stalls upstream while it is outstanding, and hands the result to MEM/WB.
//   clock, reset_n        : stage clock, async active-low reset
//   ALUResult             : address for loads/stores, result for ALU ops
//   memRead/memWrite      : load / store request
//   memToReg              : write-back selects load data
//   registerFileDataB     : store data
//   registerFileWrite     : destination register (0 = none)
//   dmem                  : data-memory bus (master side)
//   stall                 : freeze PC, IF/ID, ID/EX and EX/MEM
//   wb_valid/data/regWrite: retired instruction towards MEM/WB
//   mem_err               : one-cycle error pulse (misalign/timeout/conflict)
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memToReg,
    input  logic [DATA_W-1:0] registerFileDataB,
    input  logic [REG_W-1:0]  registerFileWrite,
    mem_access_stage_if.master dmem,
    output logic              stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_regWrite,
    output logic [1:0]        mem_err
);
    state_e            state_q;
    logic              req_q, we_q, mem_to_reg_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, alu_q;
    logic [REG_W-1:0]  dest_q;
    logic              wb_valid_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [REG_W-1:0]  wb_reg_q;
    logic [1:0]        err_q;

    logic is_conflict, is_mem_op, start_access;
    logic cnt_clear, cnt_enable, cnt_last;

    assign is_conflict  = memRead & memWrite;
    assign is_mem_op    = memRead ^ memWrite;
    assign start_access = is_mem_op & word_aligned(ALUResult[1:0]);

    assign cnt_clear  = (state_q == ST_IDLE);
    assign cnt_enable = (state_q == ST_WAIT);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .last    (cnt_last)
    );

    // Stall is combinational so upstream freezes in the very cycle an access is
    // accepted, and releases in the cycle the access ends (ack or timeout).
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            ST_IDLE: stall = start_access;
            ST_WAIT: stall = !dmem.ack && !cnt_last;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            mem_to_reg_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            alu_q        <= '0;
            dest_q       <= REG_NONE;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_reg_q     <= REG_NONE;
            err_q        <= ERR_NONE;
        end else begin
            err_q <= ERR_NONE;
            unique case (state_q)
                ST_IDLE: begin
                    if (is_conflict) begin
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= ALUResult;
                        wb_reg_q   <= REG_NONE;
                        err_q      <= ERR_CONFLICT;
                    end else if (is_mem_op && !start_access) begin
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= ALUResult;
                        wb_reg_q   <= REG_NONE;
                        err_q      <= ERR_MISALIGN;
                    end else if (start_access) begin
                        state_q      <= ST_WAIT;
                        req_q        <= 1'b1;
                        we_q         <= memWrite;
                        mem_to_reg_q <= memToReg;
                        addr_q       <= ALUResult[ADDR_W-1:0];
                        wdata_q      <= registerFileDataB;
                        alu_q        <= ALUResult;
                        dest_q       <= registerFileWrite;
                        wb_valid_q   <= 1'b0;
                        wb_reg_q     <= REG_NONE;
                    end else begin
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= ALUResult;
                        wb_reg_q   <= registerFileWrite;
                    end
                end
                ST_WAIT: begin
                    // Ack is checked first so a last-cycle ack still completes cleanly.
                    if (dmem.ack) begin
                        state_q    <= ST_IDLE;
                        req_q      <= 1'b0;
                        wb_valid_q <= 1'b1;
                        if (we_q) begin
                            wb_data_q <= alu_q;
                            wb_reg_q  <= REG_NONE;
                        end else begin
                            wb_data_q <= mem_to_reg_q ? dmem.rdata : alu_q;
                            wb_reg_q  <= dest_q;
                        end
                    end else if (cnt_last) begin
                        state_q    <= ST_IDLE;
                        req_q      <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= alu_q;
                        wb_reg_q   <= REG_NONE;
                        err_q      <= ERR_TIMEOUT;
                    end else begin
                        wb_valid_q <= 1'b0;
                        wb_reg_q   <= REG_NONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmem.req    = req_q;
    assign dmem.we     = we_q;
    assign dmem.addr   = addr_q;
    assign dmem.wdata  = wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_regWrite = wb_reg_q;
    assign mem_err     = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Expected retirements are queued when
// an instruction is presented and popped when the stage retires it.
module tb_mem_access_stage;
    import pipeline_pkg::*;

    localparam int unsigned TO = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ALUResult;
    logic        memRead, memWrite, memToReg;
    logic [31:0] registerFileDataB;
    logic [3:0]  registerFileWrite;
    logic        stall, wb_valid;
    logic [31:0] wb_data;
    logic [3:0]  wb_regWrite;
    logic [1:0]  mem_err;

    mem_access_stage_if #(.ADDR_W(32)) dmem ();

    mem_access_stage #(
        .TIMEOUT (TO),
        .ADDR_W  (32)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .ALUResult         (ALUResult),
        .memRead           (memRead),
        .memWrite          (memWrite),
        .memToReg          (memToReg),
        .registerFileDataB (registerFileDataB),
        .registerFileWrite (registerFileWrite),
        .dmem              (dmem.master),
        .stall             (stall),
        .wb_valid          (wb_valid),
        .wb_data           (wb_data),
        .wb_regWrite       (wb_regWrite),
        .mem_err           (mem_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd;
        logic [1:0]  err;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] b, input logic [3:0] dst);
        memRead           = rd;
        memWrite          = wr;
        memToReg          = m2r;
        ALUResult         = alu;
        registerFileDataB = b;
        registerFileWrite = dst;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h0;
        nop();
        repeat (2) tick();
        n_cmp++;
        if (dmem.req !== 1'b0 || dmem.we !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0
            || mem_err !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ctrl: req=%b we=%b stall=%b wb_valid=%b err=%b, want all 0",
                     dmem.req, dmem.we, stall, wb_valid, mem_err);
        end
        n_cmp++;
        if (dmem.addr !== 32'h0 || dmem.wdata !== 32'h0 || wb_data !== 32'h0
            || wb_regWrite !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h rd=%0d, want all 0",
                     dmem.addr, dmem.wdata, wb_data, wb_regWrite);
        end
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        logic [31:0] alus [3] = '{32'h0000_1234, 32'hFFFF_FFFC, 32'h8000_0001};
        logic [3:0]  rds  [3] = '{4'd5, 4'd15, 4'd0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, alus[i], 32'h5A5A_5A5A, rds[i]);
            sb.push_back('{alus[i], rds[i], ERR_NONE, 1'b1});
            #1;
            n_cmp++;
            if (stall !== 1'b0) begin
                n_bad++;
                $display("FAIL alu_stall[%0d]: stall=%b, want 0", i, stall);
            end
            tick();
            n_cmp++;
            if (dmem.req !== 1'b0) begin
                n_bad++;
                $display("FAIL alu_no_req[%0d]: req=%b, want 0", i, dmem.req);
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL alu_retire: scoreboard empty, wb_valid=%b want 1", wb_valid);
            end else begin
                e = sb.pop_front();
                if (wb_valid !== 1'b1 || wb_regWrite !== e.rd || mem_err !== e.err
                    || (e.chk_data && wb_data !== e.data)) begin
                    n_bad++;
                    $display("FAIL alu_retire[%0d]: v=%b d=%h rd=%0d err=%b, want v=1 d=%h rd=%0d err=%b",
                             i, wb_valid, wb_data, wb_regWrite, mem_err, e.data, e.rd, e.err);
                end
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'd3);
        sb.push_back('{32'hDEAD_BEEF, 4'd3, ERR_NONE, 1'b1});
        #1;
        n_cmp++;
        if (stall !== 1'b1 || dmem.req !== 1'b0) begin
            n_bad++;
            $display("FAIL load_accept: stall=%b req=%b, want stall=1 req=0", stall, dmem.req);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0777, 32'h0, 4'd9);
        n_cmp++;
        if (dmem.req !== 1'b1 || dmem.we !== 1'b0 || dmem.addr !== 32'h100) begin
            n_bad++;
            $display("FAIL load_bus: req=%b we=%b addr=%h, want req=1 we=0 addr=00000100",
                     dmem.req, dmem.we, dmem.addr);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (stall !== 1'b1 || wb_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL load_wait[%0d]: stall=%b wb_valid=%b, want stall=1 wb_valid=0",
                         c, stall, wb_valid);
            end
            tick();
        end
        // Fourth WAIT cycle coincides with the timeout terminal count: ack must win.
        dmem.ack   = 1'b1;
        dmem.rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL load_ack_stall: stall=%b, want 0", stall);
        end
        tick();
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h0;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL load_retire: scoreboard empty, wb_valid=%b want 1", wb_valid);
        end else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || wb_regWrite !== e.rd || mem_err !== e.err
                || (e.chk_data && wb_data !== e.data) || dmem.req !== 1'b0) begin
                n_bad++;
                $display("FAIL load_retire: v=%b d=%h rd=%0d err=%b req=%b, want v=1 d=%h rd=%0d err=%b req=0",
                         wb_valid, wb_data, wb_regWrite, mem_err, dmem.req, e.data, e.rd, e.err);
            end
        end
    endtask

    task automatic test_store();
        exp_t e;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 4'd7);
        sb.push_back('{32'h0000_0204, REG_NONE, ERR_NONE, 1'b1});
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL store_accept: stall=%b, want 1", stall);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0999, 32'h1111_1111, 4'd1);
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || dmem.addr !== 32'h204
                || dmem.wdata !== 32'hCAFE_F00D) begin
                n_bad++;
                $display("FAIL store_hold[%0d]: req=%b we=%b addr=%h wdata=%h, want 1 1 00000204 cafef00d",
                         c, dmem.req, dmem.we, dmem.addr, dmem.wdata);
            end
            tick();
        end
        dmem.ack = 1'b1;
        tick();
        dmem.ack = 1'b0;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL store_retire: scoreboard empty, wb_valid=%b want 1", wb_valid);
        end else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || wb_regWrite !== e.rd || mem_err !== e.err
                || (e.chk_data && wb_data !== e.data)) begin
                n_bad++;
                $display("FAIL store_retire: v=%b d=%h rd=%0d err=%b, want v=1 d=%h rd=%0d err=%b",
                         wb_valid, wb_data, wb_regWrite, mem_err, e.data, e.rd, e.err);
            end
        end
    endtask

    task automatic test_bad_op(input logic rd, input logic wr, input logic [31:0] alu,
                               input logic [1:0] want_err);
        exp_t e;
        drive(rd, wr, 1'b1, alu, 32'h0, 4'd6);
        sb.push_back('{alu, REG_NONE, want_err, 1'b0});
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_op_stall(err %b): stall=%b, want 0", want_err, stall);
        end
        tick();
        nop();
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL bad_op_retire: scoreboard empty, wb_valid=%b want 1", wb_valid);
        end else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || wb_regWrite !== e.rd || mem_err !== e.err
                || dmem.req !== 1'b0) begin
                n_bad++;
                $display("FAIL bad_op_retire: v=%b rd=%0d err=%b req=%b, want v=1 rd=%0d err=%b req=0",
                         wb_valid, wb_regWrite, mem_err, dmem.req, e.rd, e.err);
            end
        end
        tick();
        n_cmp++;
        if (mem_err !== ERR_NONE || dmem.req !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_op_pulse(err %b): err=%b req=%b, want err=00 req=0",
                     want_err, mem_err, dmem.req);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   req_cycles = 0;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'd8);
        sb.push_back('{32'h0, REG_NONE, ERR_TIMEOUT, 1'b0});
        tick();
        nop();
        for (int i = 0; i < 10; i++) begin
            if (dmem.req !== 1'b1) break;
            req_cycles++;
            #1;
            n_cmp++;
            if (stall !== (req_cycles != TO)) begin
                n_bad++;
                $display("FAIL timeout_stall[%0d]: stall=%b, want %b",
                         req_cycles, stall, (req_cycles != TO));
            end
            tick();
        end
        n_cmp++;
        if (req_cycles != TO) begin
            n_bad++;
            $display("FAIL timeout_req_len: req high %0d cycles, want %0d", req_cycles, TO);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL timeout_retire: scoreboard empty, wb_valid=%b want 1", wb_valid);
        end else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || wb_regWrite !== e.rd || mem_err !== e.err) begin
                n_bad++;
                $display("FAIL timeout_retire: v=%b rd=%0d err=%b, want v=1 rd=%0d err=%b",
                         wb_valid, wb_regWrite, mem_err, e.rd, e.err);
            end
        end
        tick();
        dmem.ack   = 1'b1;
        dmem.rdata = 32'h1234_5678;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL late_ack_stall: stall=%b, want 0", stall);
        end
        tick();
        dmem.ack = 1'b0;
        n_cmp++;
        if (dmem.req !== 1'b0 || mem_err !== ERR_NONE || wb_valid !== 1'b1
            || wb_regWrite !== 4'd0 || wb_data !== 32'h0) begin
            n_bad++;
            $display("FAIL late_ack_ignored: req=%b err=%b v=%b rd=%0d d=%h, want 0 00 1 0 00000000",
                     dmem.req, mem_err, wb_valid, wb_regWrite, wb_data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'd2);
        sb.push_back('{32'h0000_0300, 4'd2, ERR_NONE, 1'b1});
        tick();
        // Upstream advances on the ack edge, so the next op is already waiting.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0304, 32'h0000_00AB, 4'd4);
        sb.push_back('{32'h0000_0304, REG_NONE, ERR_NONE, 1'b1});
        dmem.ack   = 1'b1;
        dmem.rdata = 32'h1111_1111;
        tick();
        dmem.ack = 1'b0;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_first_retire: scoreboard empty, wb_valid=%b want 1", wb_valid);
        end else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || wb_regWrite !== e.rd || mem_err !== e.err
                || wb_data !== e.data) begin
                n_bad++;
                $display("FAIL b2b_first_retire: v=%b d=%h rd=%0d err=%b, want v=1 d=%h rd=%0d err=%b",
                         wb_valid, wb_data, wb_regWrite, mem_err, e.data, e.rd, e.err);
            end
        end
        #1;
        n_cmp++;
        if (dmem.req !== 1'b0 || stall !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_gap: req=%b stall=%b, want req=0 stall=1", dmem.req, stall);
        end
        tick();
        nop();
        n_cmp++;
        if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || dmem.addr !== 32'h304
            || dmem.wdata !== 32'hAB) begin
            n_bad++;
            $display("FAIL b2b_second_bus: req=%b we=%b addr=%h wdata=%h, want 1 1 00000304 000000ab",
                     dmem.req, dmem.we, dmem.addr, dmem.wdata);
        end
        dmem.ack = 1'b1;
        tick();
        dmem.ack = 1'b0;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_second_retire: scoreboard empty, wb_valid=%b want 1", wb_valid);
        end else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || wb_regWrite !== e.rd || mem_err !== e.err
                || wb_data !== e.data) begin
                n_bad++;
                $display("FAIL b2b_second_retire: v=%b d=%h rd=%0d err=%b, want v=1 d=%h rd=%0d err=%b",
                         wb_valid, wb_data, wb_regWrite, mem_err, e.data, e.rd, e.err);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 4'd2);
        tick();
        nop();
        tick();
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (dmem.req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait_async: req=%b stall=%b wb_valid=%b, want all 0",
                     dmem.req, stall, wb_valid);
        end
        tick();
        #2 reset_n = 1'b1;
        dmem.ack   = 1'b1;
        dmem.rdata = 32'hBAD0_BAD0;
        tick();
        dmem.ack = 1'b0;
        n_cmp++;
        if (dmem.req !== 1'b0 || wb_regWrite !== 4'd0 || mem_err !== ERR_NONE) begin
            n_bad++;
            $display("FAIL rst_wait_ack_ignored: req=%b rd=%0d err=%b, want req=0 rd=0 err=00",
                     dmem.req, wb_regWrite, mem_err);
        end
        drive(1'b0, 1'b0, 1'b0, 32'hA5A5_0000, 32'h0, 4'd9);
        sb.push_back('{32'hA5A5_0000, 4'd9, ERR_NONE, 1'b1});
        tick();
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL rst_wait_alu: scoreboard empty, wb_valid=%b want 1", wb_valid);
        end else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || wb_regWrite !== e.rd || mem_err !== e.err
                || wb_data !== e.data) begin
                n_bad++;
                $display("FAIL rst_wait_alu: v=%b d=%h rd=%0d err=%b, want v=1 d=%h rd=%0d err=%b",
                         wb_valid, wb_data, wb_regWrite, mem_err, e.data, e.rd, e.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_bad_op(1'b1, 1'b0, 32'h0000_0102, ERR_MISALIGN);
        test_bad_op(1'b1, 1'b1, 32'h0000_0200, ERR_CONFLICT);
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage between the EX/MEM latch and the MEM/WB latch.
- Takes the latched ALU result, memory controls, store data and destination register, and runs a req/ack transaction on the data-memory bus.
- Stalls the front of the pipeline until the transaction completes, then presents write-back data to the MEM/WB latch.
- Checks word alignment, conflicting controls and bus timeout.

Parameters:
- TIMEOUT, 16, max WAIT cycles without dmem_ack before the access is aborted (range 1..255).
- ADDR_W, 32, data-memory address width.

Ports:
- clock  in  1  stage clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ALUResult  in  32  address for loads/stores; result for ALU ops.
- memRead  in  1  load request.
- memWrite  in  1  store request.
- memToReg  in  1  write-back selects memory data.
- registerFileDataB  in  32  store data.
- registerFileWrite  in  4  destination register; 0 = no write.
- dmem_req  out  1  bus request, held until ack or abort.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  word address, taken from ALUResult[ADDR_W-1:0].
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid only with dmem_ack.
- dmem_ack  in  1  single-cycle completion strobe.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- wb_valid  out  1  wb_* outputs carry a retired instruction this cycle.
- wb_data  out  32  ALU result or load data per memToReg.
- wb_regWrite  out  4  destination register; 0 = suppress write.
- mem_err  out  2  one-cycle error pulse: 01 misaligned, 10 timeout, 11 read&write conflict.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE and the timeout counter clears.
  - dmem_req, dmem_we, wb_valid, stall and mem_err go to 0.
  - dmem_addr, dmem_wdata, wb_data and wb_regWrite go to 0.
  - Reset mid-WAIT drops dmem_req immediately; a later ack is ignored.
- States: IDLE, WAIT.
- IDLE, no memory op (memRead=memWrite=0):
  - Registered pass-through, 1-cycle latency.
  - wb_valid=1, wb_data=ALUResult, wb_regWrite=registerFileWrite.
- IDLE, memRead XOR memWrite, ALUResult[1:0]=00:
  - stall=1 combinationally in the same cycle.
  - At the edge: latch addr, wdata, we, memToReg and dest; set dmem_req=1; clear counter; go to WAIT; emit a bubble (wb_valid=0, wb_regWrite=0).
- IDLE, memory op with ALUResult[1:0]!=00:
  - No bus access; mem_err=01 for one cycle.
  - Retire as a bubble: wb_valid=1, wb_regWrite=0.
- IDLE, memRead=memWrite=1: no access; mem_err=11; retire as a bubble, as above.
- WAIT, dmem_ack=0:
  - stall=1; bus outputs held stable; wb_valid=0.
  - Counter increments each cycle.
- WAIT, dmem_ack=1:
  - stall=0 in that cycle, so upstream advances on the same edge.
  - At the edge: dmem_req=0, return to IDLE, wb_valid=1.
  - Load: wb_data = memToReg ? dmem_rdata : latched ALUResult; wb_regWrite = latched dest.
  - Store: wb_regWrite=0, wb_data=latched address.
- WAIT timeout (counter=TIMEOUT-1 with no ack):
  - stall=0 that cycle.
  - At the edge: dmem_req=0, mem_err=10, wb_valid=1, wb_regWrite=0, return to IDLE.
- Ack and timeout in the same cycle: the ack wins; no error.
- dmem_ack while IDLE: ignored, no state change.
- Upstream inputs are only sampled in IDLE; in WAIT they are don't-care because upstream is frozen by stall.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle after the ack edge, so there is at least one req-low cycle between transactions.
- mem_err is 00 whenever no error event occurs.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding constants ST_IDLE and ST_WAIT;
  - mem_err codes ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT, ERR_CONFLICT;
  - REG_NONE=4'd0.
- One sub-module is natural: mem_timeout_counter (clear, enable, terminal-count output, parameter TIMEOUT).
- The rest is a single FSM with output registers.

Test Plan:
- ALU op ALUResult=0x0000_1234, registerFileWrite=5 → next edge: wb_valid=1, wb_data=0x1234, wb_regWrite=5, stall=0, dmem_req=0.
- Load from 0x100 with memToReg=1, dest=3; ack after 3 cycles with rdata=0xDEADBEEF → stall high for 3 cycles with wb_valid=0, then wb_data=0xDEADBEEF, wb_regWrite=3.
- Store 0xCAFEF00D to 0x204 → dmem_req=1, dmem_we=1, dmem_addr=0x204, dmem_wdata=0xCAFEF00D held until ack; retire with wb_regWrite=0.
- Load to 0x102 → no dmem_req; mem_err=01 for one cycle; wb_regWrite=0.
- memRead=memWrite=1 → no dmem_req; mem_err=11 for one cycle; wb_regWrite=0.
- Load, no ack, TIMEOUT=4 → dmem_req high for exactly 4 cycles, mem_err=10, then IDLE; an ack arriving 2 cycles later is ignored.
- Assert reset_n=0 mid-WAIT → dmem_req and stall drop asynchronously; after release, an ALU op passes through normally.
